// File: rtl/regfile_wb_arbiter_if.sv
// ============================================================================
//  Module   : regfile_wb_arbiter_if
//  Brief    : Writeback request, write-port and bypass signal bundle.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface regfile_wb_arbiter_if #(
    parameter int DATA_W   = 16,
    parameter int REG_ID_W = 4
);
    logic                req0_valid;
    logic [REG_ID_W-1:0] req0_reg;
    logic [DATA_W-1:0]   req0_data;
    logic                req0_ready;
    logic                req1_valid;
    logic [REG_ID_W-1:0] req1_reg;
    logic [DATA_W-1:0]   req1_data;
    logic                req1_ready;
    logic                stall;
    logic                flush;
    logic                WriteReg;
    logic [REG_ID_W-1:0] DstReg;
    logic [DATA_W-1:0]   DstData;
    logic [REG_ID_W-1:0] SrcReg1;
    logic [REG_ID_W-1:0] SrcReg2;
    logic                Byp1_hit;
    logic [DATA_W-1:0]   Byp1_data;
    logic                Byp2_hit;
    logic [DATA_W-1:0]   Byp2_data;

    modport slave (
        input  req0_valid, req0_reg, req0_data,
        output req0_ready,
        input  req1_valid, req1_reg, req1_data,
        output req1_ready,
        input  stall, flush,
        output WriteReg, DstReg, DstData,
        input  SrcReg1, SrcReg2,
        output Byp1_hit, Byp1_data, Byp2_hit, Byp2_data
    );

    modport master (
        output req0_valid, req0_reg, req0_data,
        input  req0_ready,
        output req1_valid, req1_reg, req1_data,
        input  req1_ready,
        output stall, flush,
        input  WriteReg, DstReg, DstData,
        output SrcReg1, SrcReg2,
        input  Byp1_hit, Byp1_data, Byp2_hit, Byp2_data
    );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Brief    : Round-robin share of the register-file write port between two
//             writeback requesters, with a one-entry write stage and bypass.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
    parameter int DATA_W      = 16,
    parameter int REG_ID_W    = 4,
    parameter int ZERO_REG_RO = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    regfile_wb_arbiter_if.slave   bus
);
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_xfer;
    logic [REG_ID_W-1:0] w_reg;
    logic [DATA_W-1:0]   w_data;

    logic                last_grant_q, last_grant_d;
    logic                wr_q,         wr_d;
    logic [REG_ID_W-1:0] dst_reg_q,    dst_reg_d;
    logic [DATA_W-1:0]   dst_data_q,   dst_data_d;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst && !bus.stall) begin
            w_gnt0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
            w_gnt1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
        end
    end

    assign w_xfer = w_gnt0 || w_gnt1;
    assign w_reg  = w_gnt1 ? bus.req1_reg  : bus.req0_reg;
    assign w_data = w_gnt1 ? bus.req1_data : bus.req0_data;

    always_comb begin
        last_grant_d = last_grant_q;
        wr_d         = wr_q;
        dst_reg_d    = dst_reg_q;
        dst_data_d   = dst_data_q;
        if (bus.stall) begin
            if (bus.flush) begin
                wr_d = 1'b0;
            end
        end else begin
            wr_d = 1'b0;
            if (w_xfer) begin
                // A flush squashes the already-staged write, never the incoming one.
                dst_reg_d    = w_reg;
                dst_data_d   = w_data;
                wr_d         = !((ZERO_REG_RO != 0) && (w_reg == '0));
                last_grant_d = w_gnt1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            wr_q         <= 1'b0;
            dst_reg_q    <= '0;
            dst_data_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            dst_reg_q    <= dst_reg_d;
            dst_data_q   <= dst_data_d;
        end
    end

    logic w_hit1;
    logic w_hit2;

    assign w_hit1 = wr_q && (dst_reg_q == bus.SrcReg1) &&
                    !((ZERO_REG_RO != 0) && (bus.SrcReg1 == '0));
    assign w_hit2 = wr_q && (dst_reg_q == bus.SrcReg2) &&
                    !((ZERO_REG_RO != 0) && (bus.SrcReg2 == '0));

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.WriteReg   = wr_q;
    assign bus.DstReg     = dst_reg_q;
    assign bus.DstData    = dst_data_q;
    assign bus.Byp1_hit   = w_hit1;
    assign bus.Byp1_data  = w_hit1 ? dst_data_q : '0;
    assign bus.Byp2_hit   = w_hit2;
    assign bus.Byp2_data  = w_hit2 ? dst_data_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Brief    : Randomized and directed bench for regfile_wb_arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(16), .REG_ID_W(4)) bus ();

    regfile_wb_arbiter #(.DATA_W(16), .REG_ID_W(4), .ZERO_REG_RO(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the staged write as a record plus a "who goes next on a tie" bit.
    logic        m_wr   = 1'b0;
    logic [3:0]  m_reg  = 4'd0;
    logic [15:0] m_data = 16'd0;
    int          m_last = 1;

    function automatic int pick(input logic v0, input logic v1, input logic s,
                                input logic r, input int last);
        if (r || s)    return -1;
        if (v0 && v1)  return (last == 1) ? 0 : 1;
        if (v0)        return 0;
        if (v1)        return 1;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        int g;
        if (rst) begin
            m_wr = 1'b0; m_reg = 4'd0; m_data = 16'd0; m_last = 1;
        end else begin
            g = pick(bus.req0_valid, bus.req1_valid, bus.stall, rst, m_last);
            if (bus.stall) begin
                if (bus.flush) m_wr = 1'b0;
            end else if (g < 0) begin
                m_wr = 1'b0;
            end else begin
                m_reg  = (g == 1) ? bus.req1_reg  : bus.req0_reg;
                m_data = (g == 1) ? bus.req1_data : bus.req0_data;
                m_wr   = (m_reg != 4'd0);
                m_last = g;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        logic h1, h2;
        g  = pick(bus.req0_valid, bus.req1_valid, bus.stall, rst, m_last);
        h1 = m_wr && (bus.SrcReg1 == m_reg) && (bus.SrcReg1 != 4'd0);
        h2 = m_wr && (bus.SrcReg2 == m_reg) && (bus.SrcReg2 != 4'd0);
        chk("m_ready0", bus.req0_ready, g == 0);
        chk("m_ready1", bus.req1_ready, g == 1);
        chk("m_wr",     bus.WriteReg, m_wr);
        chk("m_dstreg", bus.DstReg, m_reg);
        chk("m_dstdat", bus.DstData, m_data);
        chk("m_hit1",   bus.Byp1_hit, h1);
        chk("m_dat1",   bus.Byp1_data, h1 ? m_data : 16'd0);
        chk("m_hit2",   bus.Byp2_hit, h2);
        chk("m_dat2",   bus.Byp2_data, h2 ? m_data : 16'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic a0, a1;
        bus.req0_valid = 1'b1; bus.req0_reg = 4'd1; bus.req0_data = 16'h1111;
        bus.req1_valid = 1'b1; bus.req1_reg = 4'd5; bus.req1_data = 16'hBEEF;
        bus.stall = 1'b0; bus.flush = 1'b0;
        bus.SrcReg1 = 4'd0; bus.SrcReg2 = 4'd0;
        #2 rst = 1'b1;

        // Reset: readies held low, stage empty; then the first tie goes to req0.
        repeat (2) @(negedge clk);
        chk("rst_wr", bus.WriteReg, 1'b0);
        chk("rst_rdy0", bus.req0_ready, 1'b0);
        chk("rst_rdy1", bus.req1_ready, 1'b0);
        step(); rst = 1'b0;
        @(negedge clk);
        chk("tie_rdy0", bus.req0_ready, 1'b1);
        chk("tie_rdy1", bus.req1_ready, 1'b0);

        // Single write from req1.
        step(); bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("single_rdy1", bus.req1_ready, 1'b1);
        step(); bus.req1_valid = 1'b0; bus.SrcReg1 = 4'd5;
        @(negedge clk);
        chk("single_wr", bus.WriteReg, 1'b1);
        chk("single_dst", bus.DstReg, 4'd5);
        chk("single_dat", bus.DstData, 16'hBEEF);
        chk("single_hit1", bus.Byp1_hit, 1'b1);
        chk("single_byp1", bus.Byp1_data, 16'hBEEF);

        // Contention: grants alternate starting with req0.
        step();
        bus.req0_valid = 1'b1; bus.req0_reg = 4'd2; bus.req0_data = 16'hA0A0;
        bus.req1_valid = 1'b1; bus.req1_reg = 4'd3; bus.req1_data = 16'hB0B0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("cont_rdy0", bus.req0_ready, (k % 2) == 0);
            chk("cont_rdy1", bus.req1_ready, (k % 2) == 1);
            if (k > 0) chk("cont_dst", bus.DstReg, ((k % 2) == 1) ? 4'd2 : 4'd3);
            step();
        end
        chk("cont_dst_last", bus.DstReg, 4'd3);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

        // Zero register: accepted, never written, never bypassed.
        bus.req0_valid = 1'b1; bus.req0_reg = 4'd0; bus.req0_data = 16'h1234;
        bus.SrcReg1 = 4'd0; bus.SrcReg2 = 4'd0;
        @(negedge clk);
        chk("zero_rdy0", bus.req0_ready, 1'b1);
        step(); bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("zero_wr", bus.WriteReg, 1'b0);
        chk("zero_hit1", bus.Byp1_hit, 1'b0);
        chk("zero_hit2", bus.Byp2_hit, 1'b0);

        // Stall holds the stage, then a flush kills it.
        step(); bus.req1_valid = 1'b1; bus.req1_reg = 4'd7; bus.req1_data = 16'h7777;
        @(negedge clk);
        chk("stall_acc", bus.req1_ready, 1'b1);
        step(); bus.req1_valid = 1'b0; bus.stall = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_reg = 4'd9; bus.req0_data = 16'h9999;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_rdy0", bus.req0_ready, 1'b0);
            chk("stall_dst", bus.DstReg, 4'd7);
            chk("stall_wr", bus.WriteReg, 1'b1);
            step();
        end
        bus.stall = 1'b0; bus.flush = 1'b1; bus.req0_valid = 1'b0;
        step(); bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_wr", bus.WriteReg, 1'b0);

        // Async reset mid-stream while a write is staged.
        step(); bus.req0_valid = 1'b1; bus.req0_reg = 4'd4; bus.req0_data = 16'h4444;
        @(negedge clk);
        chk("ar_acc", bus.req0_ready, 1'b1);
        step(); bus.req0_valid = 1'b0; bus.stall = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_reg = 4'd6; bus.req1_data = 16'h6666;
        @(negedge clk);
        chk("ar_wr_before", bus.WriteReg, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("ar_wr_now", bus.WriteReg, 1'b0);
        chk("ar_rdy1_rst", bus.req1_ready, 1'b0);
        #1 rst = 1'b0; bus.stall = 1'b0;
        #1;
        chk("ar_rdy1_after", bus.req1_ready, 1'b1);

        // Randomized phase; valid requests keep reg/data until accepted.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            a0 = bus.req0_valid && bus.req0_ready;
            a1 = bus.req1_valid && bus.req1_ready;
            step();
            if (!bus.req0_valid || a0) begin
                bus.req0_valid = ($urandom_range(0, 9) < 6);
                bus.req0_reg   = 4'($urandom_range(0, 7));
                bus.req0_data  = 16'($urandom);
            end
            if (!bus.req1_valid || a1) begin
                bus.req1_valid = ($urandom_range(0, 9) < 6);
                bus.req1_reg   = 4'($urandom_range(0, 7));
                bus.req1_data  = 16'($urandom);
            end
            bus.stall   = ($urandom_range(0, 4) == 0);
            bus.flush   = ($urandom_range(0, 6) == 0);
            bus.SrcReg1 = 4'($urandom_range(0, 7));
            bus.SrcReg2 = 4'($urandom_range(0, 7));
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
